fht_bank_loader: RTL and testbench
==================================

// Module: fht_bank_loader
// PURPOSE
//  Streams samples into the NUM_BANK-bank FHT working RAM ahead of iSTART of fht_top.
//  Row-major fill: sample k -> bank k%NUM_BANK, row k/NUM_BANK; row address natural or bit-reversed.
//  Converts raw ADC samples to D_BIT fixed point, or passes pre-scaled data for the IFHT pass.
//  Valid/ready input; one registered write port per bank (oWE one-hot).
// PARAMETERS
//  ADC_WIDTH  16  raw sample width, signed integer part of fixed-point word
//  D_BIT      22  RAM word width; D_BIT-ADC_WIDTH fractional bits (D_BIT > ADC_WIDTH)
//  A_BIT      8   row address width; BANK_SIZE = 2**A_BIT
//  NUM_BANK   4   number of banks, power of two >= 1; frame = NUM_BANK*BANK_SIZE samples
// PORTS
//  iCLK      in   1          clock, all logic on rising edge
//  iRESET    in   1          synchronous reset, active-high
//  iSTART    in   1          arm one frame load; sampled only in IDLE
//  iMODE     in   2          [0]: 0=ADC format, 1=fixed-point passthrough; [1]: 0=natural, 1=bit-reversed rows
//  iABORT    in   1          abandon frame, return to IDLE, no oDONE
//  iVALID    in   1          input sample valid
//  iDATA     in   D_BIT      sample; ADC format uses [ADC_WIDTH-1:0] only
//  oREADY    out  1          sample accepted when iVALID & oREADY
//  oWE       out  NUM_BANK   one-hot bank write enable
//  oADDR_WR  out  A_BIT      row address for oWE
//  oDATA     out  D_BIT      write data
//  oBUSY     out  1          high in LOAD and DONE
//  oDONE     out  1          one-cycle pulse: full frame written
//  oDROP     out  1          one-cycle pulse: iVALID seen while not in LOAD (sample discarded)
// BEHAVIOUR
//  Reset: state IDLE, counters 0, all outputs 0 from the next edge; in-flight write discarded.
//  States: IDLE -(iSTART & !iABORT)-> LOAD -(last sample accepted)-> DONE -(1 cycle)-> IDLE.
//   LOAD -(iABORT)-> IDLE. iSTART outside IDLE ignored. iMODE latched on entering LOAD, held for frame.
//  oREADY = (state==LOAD) & !iABORT, combinational from state and iABORT only; no dependence on iVALID.
//  Counters: bank_cnt (log2 NUM_BANK bits), row_cnt (A_BIT bits); bank_cnt increments per accept,
//   row_cnt increments when bank_cnt wraps NUM_BANK-1 -> 0. Last sample: row_cnt=BANK_SIZE-1 and bank_cnt=NUM_BANK-1.
//  Write latency 1: sample accepted on edge t -> oWE/oADDR_WR/oDATA valid in cycle t+1 for exactly 1 cycle.
//   oWE = 1<<bank_cnt; oADDR_WR = row_cnt, or bit-reversed row_cnt over A_BIT when iMODE[1]=1.
//   No accept in cycle -> oWE=0 next cycle; oADDR_WR/oDATA hold last value.
//  Data: ADC mode oDATA = {iDATA[ADC_WIDTH-1:0], (D_BIT-ADC_WIDTH)'b0} (two's-complement preserved);
//   passthrough oDATA = iDATA. No rounding, no saturation.
//  DONE: entered the cycle the last write is presented; oDONE=1 the cycle after (state DONE), oREADY=0.
//  iABORT in LOAD: that cycle's sample not accepted, no write follows, counters cleared, oDONE never asserted.
//   iABORT with last accept same cycle: abort wins. iABORT with iSTART in IDLE: stay IDLE.
//  iABORT in DONE: ignored; oDONE still pulses.
//  oDROP = registered (iVALID & !oREADY & state!=LOAD); no oDROP for backpressure inside LOAD.
//  NUM_BANK=1: bank_cnt absent, oWE constant 1 on each write.
// TESTING (defaults, frame = 1024 samples)
//  T1 ADC natural: iMODE=0, iDATA=k for k=0..1023 back-to-back -> 1024 writes, bank k%4, addr k/4,
//     data k<<6; oDONE exactly 1 cycle after the write of k=1023, then oBUSY=0.
//  T2 bit-rev passthrough: iMODE=3 -> row 1 (k=4..7) at addr 128, row 3 at addr 192, row 255 at addr 255, data unchanged.
//  T3 sign/format: ADC 0x8000 -> 0x200000, 0xFFFF -> 0x3FFFC0, 0x7FFF -> 0x1FFFC0.
//  T4 backpressure: iVALID high every 3rd cycle -> same 1024 writes as T1, one per accept, no gaps lost.
//  T5 abort/restart: iABORT during accept of k=500 -> no write for k>=500, no oDONE; new iSTART -> first write bank 0 addr 0.
//  T6 reset/idle: iRESET mid-frame -> all outputs 0 next cycle; iVALID in IDLE -> oDROP pulse, oWE=0; iSTART in LOAD ignored.

Source files
------------

// File: rtl/fht_bank_loader.sv
// Streams one frame of samples into the banked FHT working RAM, row-major across banks,
// with optional bit-reversed row addressing and ADC-to-fixed-point conversion.
`timescale 1ns/1ps

module fht_bank_loader #(
  parameter int ADC_WIDTH = 16,
  parameter int D_BIT     = 22,
  parameter int A_BIT     = 8,
  parameter int NUM_BANK  = 4
) (
  input  logic                iCLK,
  input  logic                iRESET,
  input  logic                iSTART,
  input  logic [1:0]          iMODE,
  input  logic                iABORT,
  input  logic                iVALID,
  input  logic [D_BIT-1:0]    iDATA,
  output logic                oREADY,
  output logic [NUM_BANK-1:0] oWE,
  output logic [A_BIT-1:0]    oADDR_WR,
  output logic [D_BIT-1:0]    oDATA,
  output logic                oBUSY,
  output logic                oDONE,
  output logic                oDROP
);

  // A single-bank build keeps a 1-bit bank counter that is held at zero.
  localparam int BANK_BIT = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
  localparam int FRAC_BIT = D_BIT - ADC_WIDTH;
  localparam logic [BANK_BIT-1:0] BANK_LAST = BANK_BIT'(NUM_BANK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [1:0]          mode;
  logic [BANK_BIT-1:0] bank_cnt;
  logic [A_BIT-1:0]    row_cnt;

  logic                accept;
  logic                last_sample;
  logic [BANK_BIT-1:0] bank_next;
  logic [A_BIT-1:0]    row_next;
  logic [NUM_BANK-1:0] we_onehot;
  logic [A_BIT-1:0]    wr_addr;
  logic [D_BIT-1:0]    wr_data;

  function automatic logic [A_BIT-1:0] bit_reverse(input logic [A_BIT-1:0] a);
    logic [A_BIT-1:0] r;
    r = '0;
    for (int i = 0; i < A_BIT; i++) begin
      r[i] = a[A_BIT-1-i];
    end
    return r;
  endfunction

  assign oREADY      = (state == LOAD) & ~iABORT;
  assign oBUSY       = (state == LOAD) | (state == DONE);
  assign accept      = iVALID & oREADY;
  assign last_sample = (row_cnt == {A_BIT{1'b1}}) && (bank_cnt == BANK_LAST);

  always_comb begin
    bank_next = '0;
    row_next  = row_cnt;
    if (NUM_BANK > 1) begin
      bank_next = bank_cnt + 1'b1;
    end
    if (bank_cnt == BANK_LAST) begin
      row_next = row_cnt + 1'b1;
    end
    we_onehot = NUM_BANK'(1) << bank_cnt;
    wr_addr   = mode[1] ? bit_reverse(row_cnt) : row_cnt;
    // ADC words become the integer part; the fraction is zero-filled, sign kept in the MSB.
    wr_data   = mode[0] ? iDATA : {iDATA[ADC_WIDTH-1:0], {FRAC_BIT{1'b0}}};
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state    <= IDLE;
      mode     <= '0;
      bank_cnt <= '0;
      row_cnt  <= '0;
      oWE      <= '0;
      oADDR_WR <= '0;
      oDATA    <= '0;
      oDONE    <= 1'b0;
      oDROP    <= 1'b0;
    end else begin
      oWE   <= '0;
      oDONE <= 1'b0;
      oDROP <= iVALID & ~oREADY & (state != LOAD);
      unique case (state)
        IDLE: begin
          if (iSTART && !iABORT) begin
            state    <= LOAD;
            mode     <= iMODE;
            bank_cnt <= '0;
            row_cnt  <= '0;
          end
        end
        LOAD: begin
          // Abort beats a same-cycle accept, including the final one.
          if (iABORT) begin
            state    <= IDLE;
            bank_cnt <= '0;
            row_cnt  <= '0;
          end else if (accept) begin
            oWE      <= we_onehot;
            oADDR_WR <= wr_addr;
            oDATA    <= wr_data;
            bank_cnt <= bank_next;
            row_cnt  <= row_next;
            if (last_sample) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          oDONE <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fht_bank_loader.sv
// Directed bench for fht_bank_loader: full frames in each mode, backpressure, abort,
// reset and idle-drop behaviour against hand-derived write sequences.
`timescale 1ns/1ps

module tb_fht_bank_loader;

  localparam int ADC_WIDTH = 16;
  localparam int D_BIT     = 22;
  localparam int A_BIT     = 8;
  localparam int NUM_BANK  = 4;
  localparam int FRAME     = 1024;

  logic                iCLK;
  logic                iRESET;
  logic                iSTART;
  logic [1:0]          iMODE;
  logic                iABORT;
  logic                iVALID;
  logic [D_BIT-1:0]    iDATA;
  logic                oREADY;
  logic [NUM_BANK-1:0] oWE;
  logic [A_BIT-1:0]    oADDR_WR;
  logic [D_BIT-1:0]    oDATA;
  logic                oBUSY;
  logic                oDONE;
  logic                oDROP;

  int checks   = 0;
  int failures = 0;

  fht_bank_loader #(
    .ADC_WIDTH(ADC_WIDTH),
    .D_BIT    (D_BIT),
    .A_BIT    (A_BIT),
    .NUM_BANK (NUM_BANK)
  ) dut (
    .iCLK    (iCLK),
    .iRESET  (iRESET),
    .iSTART  (iSTART),
    .iMODE   (iMODE),
    .iABORT  (iABORT),
    .iVALID  (iVALID),
    .iDATA   (iDATA),
    .oREADY  (oREADY),
    .oWE     (oWE),
    .oADDR_WR(oADDR_WR),
    .oDATA   (oDATA),
    .oBUSY   (oBUSY),
    .oDONE   (oDONE),
    .oDROP   (oDROP)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [1:0] mode, input logic abort,
                               input logic valid, input logic [D_BIT-1:0] data);
    iSTART = start;
    iMODE  = mode;
    iABORT = abort;
    iVALID = valid;
    iDATA  = data;
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  function automatic logic [A_BIT-1:0] bitrev8(input logic [A_BIT-1:0] a);
    logic [A_BIT-1:0] r;
    for (int i = 0; i < A_BIT; i++) r[i] = a[A_BIT-1-i];
    return r;
  endfunction

  // ADC samples carry junk above bit 15 that the loader must ignore.
  function automatic logic [D_BIT-1:0] sampleFor(input logic [1:0] mode, input int k);
    logic [15:0] s;
    if (mode[0]) return 22'(k * 5381) ^ 22'h2AAAAA;
    case (k)
      0:       s = 16'h8000;
      1:       s = 16'hFFFF;
      2:       s = 16'h7FFF;
      default: s = 16'(k);
    endcase
    return {6'h2A, s};
  endfunction

  function automatic logic [D_BIT-1:0] expectedFor(input logic [1:0] mode, input int k);
    if (mode[0]) return sampleFor(mode, k);
    case (k)
      0:       return 22'h200000;
      1:       return 22'h3FFFC0;
      2:       return 22'h1FFFC0;
      default: return 22'(k * 64);
    endcase
  endfunction

  // Loads one frame; abortAt < FRAME abandons it when that sample is offered.
  task automatic runFrame(input logic [1:0] mode, input int gap, input int abortAt);
    logic [A_BIT-1:0] row;
    applyStimulus(1'b1, mode, 1'b0, 1'b0, '0);
    tick();
    iSTART = 1'b0;
    iMODE  = ~mode;
    #1;
    checkOutput("busy_after_start", 32'(oBUSY), 32'd1);
    checkOutput("ready_in_load", 32'(oREADY), 32'd1);
    for (int k = 0; k < FRAME; k++) begin
      for (int g = 0; g < gap; g++) begin
        tick();
        checkOutput("we_idle_gap", 32'(oWE), 32'd0);
      end
      iVALID = 1'b1;
      iDATA  = sampleFor(mode, k);
      if (k == abortAt) begin
        iABORT = 1'b1;
        #1;
        checkOutput("ready_during_abort", 32'(oREADY), 32'd0);
        tick();
        applyStimulus(1'b0, mode, 1'b0, 1'b0, '0);
        checkOutput("we_after_abort", 32'(oWE), 32'd0);
        checkOutput("busy_after_abort", 32'(oBUSY), 32'd0);
        for (int w = 0; w < 4; w++) begin
          tick();
          checkOutput("no_done_after_abort", 32'(oDONE), 32'd0);
          checkOutput("no_we_after_abort", 32'(oWE), 32'd0);
        end
        return;
      end
      iSTART = (k == 10);
      tick();
      iVALID = 1'b0;
      iSTART = 1'b0;
      row = 8'(k / NUM_BANK);
      checkOutput("we_onehot", 32'(oWE), 32'(4'b0001 << (k % NUM_BANK)));
      checkOutput("addr_wr", 32'(oADDR_WR), 32'(mode[1] ? bitrev8(row) : row));
      checkOutput("data_wr", 32'(oDATA), 32'(expectedFor(mode, k)));
      checkOutput("done_early", 32'(oDONE), 32'd0);
    end
    checkOutput("busy_in_done", 32'(oBUSY), 32'd1);
    checkOutput("ready_in_done", 32'(oREADY), 32'd0);
    // Abort in DONE must not suppress oDONE; the sample offered here is dropped.
    applyStimulus(1'b0, mode, 1'b1, 1'b1, 22'h155555);
    tick();
    applyStimulus(1'b0, mode, 1'b0, 1'b0, '0);
    checkOutput("done_pulse", 32'(oDONE), 32'd1);
    checkOutput("drop_in_done", 32'(oDROP), 32'd1);
    checkOutput("busy_after_done", 32'(oBUSY), 32'd0);
    checkOutput("we_after_done", 32'(oWE), 32'd0);
    tick();
    checkOutput("done_one_cycle", 32'(oDONE), 32'd0);
    checkOutput("drop_one_cycle", 32'(oDROP), 32'd0);
  endtask

  initial begin
    $display("[TB] start");
    iRESET = 1'b1;
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, '0);
    repeat (3) tick();
    checkOutput("reset_we", 32'(oWE), 32'd0);
    checkOutput("reset_addr", 32'(oADDR_WR), 32'd0);
    checkOutput("reset_data", 32'(oDATA), 32'd0);
    checkOutput("reset_busy", 32'(oBUSY), 32'd0);
    checkOutput("reset_ready", 32'(oREADY), 32'd0);
    checkOutput("reset_done", 32'(oDONE), 32'd0);
    checkOutput("reset_drop", 32'(oDROP), 32'd0);
    iRESET = 1'b0;
    tick();

    $display("[TB] idle drop and start+abort");
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 22'h001234);
    tick();
    iVALID = 1'b0;
    checkOutput("idle_drop", 32'(oDROP), 32'd1);
    checkOutput("idle_drop_we", 32'(oWE), 32'd0);
    tick();
    checkOutput("idle_drop_clear", 32'(oDROP), 32'd0);
    applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, '0);
    tick();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, '0);
    #1;
    checkOutput("start_abort_busy", 32'(oBUSY), 32'd0);
    checkOutput("start_abort_ready", 32'(oREADY), 32'd0);

    $display("[TB] ADC natural frame");
    runFrame(2'b00, 0, FRAME);
    $display("[TB] bit-reversed passthrough frame");
    runFrame(2'b11, 0, FRAME);
    $display("[TB] ADC natural frame with backpressure");
    runFrame(2'b00, 2, FRAME);
    $display("[TB] abort at sample 500");
    runFrame(2'b00, 0, 500);

    $display("[TB] restart after abort, then reset mid-frame");
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, '0);
    tick();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, sampleFor(2'b00, 0));
    tick();
    iVALID = 1'b0;
    checkOutput("restart_we", 32'(oWE), 32'd1);
    checkOutput("restart_addr", 32'(oADDR_WR), 32'd0);
    checkOutput("restart_data", 32'(oDATA), 32'h200000);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, sampleFor(2'b00, 1));
    iRESET = 1'b1;
    tick();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, '0);
    checkOutput("midreset_we", 32'(oWE), 32'd0);
    checkOutput("midreset_addr", 32'(oADDR_WR), 32'd0);
    checkOutput("midreset_data", 32'(oDATA), 32'd0);
    checkOutput("midreset_busy", 32'(oBUSY), 32'd0);
    checkOutput("midreset_ready", 32'(oREADY), 32'd0);
    checkOutput("midreset_drop", 32'(oDROP), 32'd0);
    iRESET = 1'b0;
    tick();
    checkOutput("post_reset_idle", 32'(oBUSY), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
